// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// cache_pkg: shared state encoding, field widths and byte-lane helper. Rev 1.0
// ============================================================================
package cache_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REFILL = 2'd1,
      WRITE  = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int DATA_W         = 32;
   localparam int BYTE_OFF_W     = 2;
   localparam int DEF_ADDR_WIDTH = 32;
   localparam int DEF_NUM_LINES  = 16;
   localparam int DEF_WORDS      = 4;
   localparam int OFFSET_W       = $clog2(DEF_WORDS);
   localparam int INDEX_W        = $clog2(DEF_NUM_LINES);
   localparam int TAG_W          = DEF_ADDR_WIDTH - INDEX_W - OFFSET_W - BYTE_OFF_W;

   // Store byte enables: a single lane for sb, otherwise the whole word.
   function automatic logic [3:0] byte_lane_en(input logic [1:0] i_off, input logic i_sb);
      return i_sb ? (4'b0001 << i_off) : 4'hF;
   endfunction

endpackage
`default_nettype wire

// File: rtl/data_cache_if.sv
`default_nettype none
// ============================================================================
// data_cache_if: request/acknowledge bus to the backing data memory. Rev 1.0
// ============================================================================
interface data_cache_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  mem_req;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [31:0]           mem_wdata;
   logic [3:0]            mem_be;
   logic [31:0]           mem_rdata;
   logic                  mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      output mem_rdata, mem_ack
   );
endinterface
`default_nettype wire

// File: rtl/cache_array.sv
`default_nettype none
// ============================================================================
// cache_array: valid/tag/data storage, one async read port, one masked write. Rev 1.0
// ============================================================================
module cache_array #(
   parameter int NUM_LINES      = 16,
   parameter int WORDS_PER_LINE = 4,
   parameter int TAG_BITS       = 24,
   parameter int IDX_BITS       = $clog2(NUM_LINES),
   parameter int CNT_W          = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1
) (
   input  wire logic                clock,
   input  wire logic                reset,
   input  wire logic [IDX_BITS-1:0] i_idx,
   input  wire logic [CNT_W-1:0]    i_rword,
   output logic                     o_valid,
   output logic [TAG_BITS-1:0]      o_tag,
   output logic [31:0]              o_rdata,
   input  wire logic                i_we,
   input  wire logic [CNT_W-1:0]    i_wword,
   input  wire logic [3:0]          i_wbe,
   input  wire logic [31:0]         i_wdata,
   input  wire logic                i_fill,
   input  wire logic [TAG_BITS-1:0] i_fill_tag
);
   logic [NUM_LINES-1:0] r_valid;
   logic [TAG_BITS-1:0]  r_tag  [NUM_LINES];
   logic [31:0]          r_data [NUM_LINES][WORDS_PER_LINE];

   assign o_valid = r_valid[i_idx];
   assign o_tag   = r_tag[i_idx];
   assign o_rdata = r_data[i_idx][i_rword];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_valid <= '0;
      end else if (i_fill) begin
         r_valid[i_idx] <= 1'b1;
      end
   end

   // Tag and data carry no reset; the valid bits alone gate their use.
   always_ff @(posedge clock) begin
      if (i_fill) begin
         r_tag[i_idx] <= i_fill_tag;
      end
      if (i_we) begin
         for (int b = 0; b < 4; b++) begin
            if (i_wbe[b]) begin
               r_data[i_idx][i_wword][8*b +: 8] <= i_wdata[8*b +: 8];
            end
         end
      end
   end
endmodule
`default_nettype wire

// File: rtl/data_cache.sv
`default_nettype none
// ============================================================================
// data_cache: direct-mapped write-through no-write-allocate data cache. Rev 1.0
// ============================================================================
module data_cache
   import cache_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int NUM_LINES      = 16,
   parameter int WORDS_PER_LINE = 4
) (
   input  wire logic                  clock,
   input  wire logic                  reset,
   input  wire logic [ADDR_WIDTH-1:0] dataAddress,
   input  wire logic [31:0]           writeData,
   input  wire logic                  memRead,
   input  wire logic                  memWrite,
   input  wire logic                  sb,
   output logic [31:0]                data,
   output logic                       stall,
   data_cache_if.master               mem
);
   localparam int WOFF_BITS  = $clog2(WORDS_PER_LINE);
   localparam int IDX_BITS   = $clog2(NUM_LINES);
   localparam int TAG_BITS   = ADDR_WIDTH - IDX_BITS - WOFF_BITS - 2;
   localparam int CNT_W      = (WOFF_BITS > 0) ? WOFF_BITS : 1;
   localparam int LINE_BYTES = WORDS_PER_LINE * 4;

   state_t                r_state;
   logic [CNT_W-1:0]      r_beat;
   logic                  r_req;
   logic                  r_we;
   logic [3:0]            r_be;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [31:0]           r_wdata;

   logic [IDX_BITS-1:0]   w_idx;
   logic [TAG_BITS-1:0]   w_tag;
   logic [CNT_W-1:0]      w_word;
   logic [CNT_W-1:0]      w_next_beat;
   logic [ADDR_WIDTH-1:0] w_line_base;
   logic                  w_valid;
   logic [TAG_BITS-1:0]   w_tag_rd;
   logic [31:0]           w_rdata;
   logic                  w_hit;
   logic                  w_last;
   logic                  w_store_hit;
   logic                  w_refill_ack;
   logic                  w_arr_we;
   logic [CNT_W-1:0]      w_arr_word;
   logic [3:0]            w_arr_be;
   logic [31:0]           w_store_data;
   logic [31:0]           w_arr_wdata;
   logic                  w_fill;
   logic                  w_stall_fsm;

   assign w_idx = dataAddress[2 + WOFF_BITS +: IDX_BITS];
   assign w_tag = dataAddress[ADDR_WIDTH-1 -: TAG_BITS];

   generate
      if (WOFF_BITS > 0) begin : g_word_off
         assign w_word = dataAddress[2 +: CNT_W];
      end else begin : g_single_word
         assign w_word = '0;
      end
   endgenerate

   assign w_next_beat  = r_beat + 1'b1;
   assign w_line_base  = dataAddress & ~ADDR_WIDTH'(LINE_BYTES - 1);
   assign w_hit        = w_valid && (w_tag_rd == w_tag);
   assign w_last       = (r_beat == CNT_W'(WORDS_PER_LINE - 1));
   assign w_store_data = sb ? {4{writeData[7:0]}} : writeData;

   // A load+store collision is a store, so memWrite takes priority everywhere.
   assign w_store_hit  = (r_state == IDLE) && memWrite && w_hit;
   assign w_refill_ack = (r_state == REFILL) && mem.mem_ack;
   assign w_arr_we     = w_store_hit || w_refill_ack;
   assign w_arr_word   = w_refill_ack ? r_beat : w_word;
   assign w_arr_be     = w_refill_ack ? 4'hF : byte_lane_en(dataAddress[1:0], sb);
   assign w_arr_wdata  = w_refill_ack ? mem.mem_rdata : w_store_data;
   assign w_fill       = w_refill_ack && w_last;

   cache_array #(
      .NUM_LINES      (NUM_LINES),
      .WORDS_PER_LINE (WORDS_PER_LINE),
      .TAG_BITS       (TAG_BITS),
      .IDX_BITS       (IDX_BITS),
      .CNT_W          (CNT_W)
   ) u_array (
      .clock      (clock),
      .reset      (reset),
      .i_idx      (w_idx),
      .i_rword    (w_word),
      .o_valid    (w_valid),
      .o_tag      (w_tag_rd),
      .o_rdata    (w_rdata),
      .i_we       (w_arr_we),
      .i_wword    (w_arr_word),
      .i_wbe      (w_arr_be),
      .i_wdata    (w_arr_wdata),
      .i_fill     (w_fill),
      .i_fill_tag (w_tag)
   );

   assign w_stall_fsm = ((r_state == IDLE) && (memWrite || (memRead && !w_hit)))
                     || (r_state == REFILL) || (r_state == WRITE);
   assign stall = reset && w_stall_fsm;
   assign data  = memRead ? w_rdata : 32'h0;

   assign mem.mem_req   = r_req;
   assign mem.mem_we    = r_we;
   assign mem.mem_be    = r_be;
   assign mem.mem_addr  = r_addr;
   assign mem.mem_wdata = r_wdata;

   // Bus outputs are loaded on the transition edge so the beat is presented
   // in the first cycle of REFILL/WRITE, and vanish asynchronously on reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_beat  <= '0;
         r_req   <= 1'b0;
         r_we    <= 1'b0;
         r_be    <= 4'h0;
         r_addr  <= '0;
         r_wdata <= 32'h0;
      end else begin
         case (r_state)
            IDLE: begin
               if (memWrite) begin
                  r_state <= WRITE;
                  r_req   <= 1'b1;
                  r_we    <= 1'b1;
                  r_addr  <= {dataAddress[ADDR_WIDTH-1:2], 2'b00};
                  r_wdata <= w_store_data;
                  r_be    <= byte_lane_en(dataAddress[1:0], sb);
               end else if (memRead && !w_hit) begin
                  r_state <= REFILL;
                  r_req   <= 1'b1;
                  r_we    <= 1'b0;
                  r_be    <= 4'hF;
                  r_addr  <= w_line_base;
                  r_beat  <= '0;
               end
            end
            REFILL: begin
               if (mem.mem_ack) begin
                  if (w_last) begin
                     r_state <= IDLE;
                     r_req   <= 1'b0;
                     r_be    <= 4'h0;
                     r_beat  <= '0;
                  end else begin
                     r_beat <= w_next_beat;
                     r_addr <= w_line_base | (ADDR_WIDTH'(w_next_beat) << 2);
                  end
               end
            end
            WRITE: begin
               if (mem.mem_ack) begin
                  r_state <= DONE;
                  r_req   <= 1'b0;
                  r_we    <= 1'b0;
                  r_be    <= 4'h0;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_data_cache.sv
`default_nettype none
// ============================================================================
// tb_data_cache: scoreboard bench for data_cache with a one-cycle-ack memory. Rev 1.0
// ============================================================================
module tb_data_cache;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } beat_t;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] dataAddress = '0;
   logic [31:0] writeData = '0;
   logic        memRead = 1'b0;
   logic        memWrite = 1'b0;
   logic        sb = 1'b0;
   logic [31:0] data;
   logic        stall;

   int n_checks = 0;
   int n_errors = 0;
   int n_unexpected = 0;

   beat_t       exp_beats [$];
   logic [31:0] exp_data  [$];

   logic [31:0] mem_model [0:1023];
   logic        r_ack;
   logic [31:0] r_rdata;

   data_cache_if #(.ADDR_WIDTH(32)) bus ();

   data_cache #(
      .ADDR_WIDTH     (32),
      .NUM_LINES      (16),
      .WORDS_PER_LINE (4)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .dataAddress (dataAddress),
      .writeData   (writeData),
      .memRead     (memRead),
      .memWrite    (memWrite),
      .sb          (sb),
      .data        (data),
      .stall       (stall),
      .mem         (bus)
   );

   always #5 clock = ~clock;

   assign bus.mem_ack   = r_ack;
   assign bus.mem_rdata = r_rdata;

   // Backing memory: ack arrives one cycle after each request is presented.
   always @(posedge clock) begin
      if (bus.mem_req && !r_ack) begin
         r_ack   <= 1'b1;
         r_rdata <= mem_model[bus.mem_addr[11:2]];
      end else begin
         r_ack <= 1'b0;
      end
      if (bus.mem_req && r_ack && bus.mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.mem_be[b]) mem_model[bus.mem_addr[11:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
         end
      end
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   always @(negedge clock) begin : beat_monitor
      beat_t e;
      if (reset && bus.mem_req && bus.mem_ack) begin
         if (exp_beats.size() == 0) begin
            n_unexpected++;
         end else begin
            e = exp_beats.pop_front();
            check_val("beat_addr", bus.mem_addr, e.addr);
            check_val("beat_we", {31'b0, bus.mem_we}, {31'b0, e.we});
            check_val("beat_be", {28'b0, bus.mem_be}, {28'b0, e.be});
            if (e.we) check_val("beat_wdata", bus.mem_wdata, e.wdata);
         end
      end
   end

   function automatic logic [31:0] mw(input logic [31:0] a);
      return mem_model[a[11:2]];
   endfunction

   task automatic push_refill(input logic [31:0] addr);
      beat_t b;
      for (int i = 0; i < 4; i++) begin
         b.addr  = (addr & ~32'hF) + 32'(4 * i);
         b.we    = 1'b0;
         b.be    = 4'hF;
         b.wdata = '0;
         exp_beats.push_back(b);
      end
   endtask

   // Called at #1 after a rising edge; leaves the bus idle at #1 after an edge.
   task automatic do_access(input logic rd, input logic wr, input logic sbv,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input bit miss, input logic [31:0] exp_rd);
      int    n;
      int    exp_n;
      beat_t b;
      if (wr) begin
         b.addr = {addr[31:2], 2'b00};
         b.we   = 1'b1;
         if (sbv) begin
            case (addr[1:0])
               2'd0:    b.be = 4'b0001;
               2'd1:    b.be = 4'b0010;
               2'd2:    b.be = 4'b0100;
               default: b.be = 4'b1000;
            endcase
            b.wdata = {4{wd[7:0]}};
         end else begin
            b.be    = 4'hF;
            b.wdata = wd;
         end
         exp_beats.push_back(b);
         exp_n = 3;
      end else if (miss) begin
         push_refill(addr);
         exp_n = 9;
      end else begin
         exp_n = 0;
      end
      if (rd && !wr) exp_data.push_back(exp_rd);
      dataAddress = addr;
      writeData   = wd;
      memRead     = rd;
      memWrite    = wr;
      sb          = sbv;
      n = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clock);
         if (!stall) break;
         n++;
      end
      check_val($sformatf("stall_cycles_%08h", addr), 32'(n), 32'(exp_n));
      if (rd && !wr) check_val($sformatf("load_data_%08h", addr), data, exp_data.pop_front());
      @(posedge clock);
      #1;
      memRead  = 1'b0;
      memWrite = 1'b0;
      sb       = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_stall"}, {31'b0, stall}, 32'h0);
      check_val({tag, "_req"}, {31'b0, bus.mem_req}, 32'h0);
      check_val({tag, "_we"}, {31'b0, bus.mem_we}, 32'h0);
      check_val({tag, "_be"}, {28'b0, bus.mem_be}, 32'h0);
      check_val({tag, "_addr"}, bus.mem_addr, 32'h0);
      check_val({tag, "_wdata"}, bus.mem_wdata, 32'h0);
      check_val({tag, "_data"}, data, 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] old_word;
      r_ack   <= 1'b0;
      r_rdata <= '0;
      for (int i = 0; i < 1024; i++) mem_model[i] <= 32'hC0DE0000 ^ (32'(i) * 32'h9E3779B1);

      repeat (3) @(posedge clock);
      #1;
      check_reset_outputs("por");
      reset = 1'b1;
      @(posedge clock);
      #1;

      // Refill, then hits on the same line.
      do_access(1, 0, 0, 32'h104, 32'h0, 1, mw(32'h104));
      do_access(1, 0, 0, 32'h10C, 32'h0, 0, mw(32'h10C));

      // Full-word and byte store hits.
      do_access(0, 1, 0, 32'h108, 32'h12345678, 0, 32'h0);
      do_access(1, 0, 0, 32'h108, 32'h0, 0, 32'h12345678);
      old_word = mw(32'h104);
      do_access(0, 1, 1, 32'h106, 32'h000000AB, 0, 32'h0);
      do_access(1, 0, 0, 32'h104, 32'h0, 0, {old_word[31:24], 8'hAB, old_word[15:0]});

      // Store miss does not allocate.
      do_access(0, 1, 0, 32'h200, 32'hDEADBEEF, 0, 32'h0);
      do_access(1, 0, 0, 32'h200, 32'h0, 1, 32'hDEADBEEF);

      // Same-index conflicts.
      do_access(1, 0, 0, 32'h100, 32'h0, 1, mw(32'h100));
      do_access(1, 0, 0, 32'h500, 32'h0, 1, mw(32'h500));
      do_access(1, 0, 0, 32'h100, 32'h0, 1, mw(32'h100));

      // Reset while idle invalidates everything.
      reset = 1'b0;
      #2;
      check_reset_outputs("midrun");
      @(posedge clock);
      #1;
      reset = 1'b1;
      do_access(1, 0, 0, 32'h40, 32'h0, 1, mw(32'h40));
      do_access(1, 0, 0, 32'h104, 32'h0, 1, mw(32'h104));

      // Abort a refill during its second beat.
      push_refill(32'h500);
      dataAddress = 32'h500;
      memRead     = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clock);
         if (bus.mem_req && bus.mem_addr == 32'h504) break;
      end
      check_val("abort_beat1_addr", bus.mem_addr, 32'h504);
      #1;
      reset = 1'b0;
      #1;
      check_val("abort_req", {31'b0, bus.mem_req}, 32'h0);
      check_val("abort_stall", {31'b0, stall}, 32'h0);
      check_val("abort_beats_left", 32'(exp_beats.size()), 32'd3);
      exp_beats.delete();
      memRead = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock);
      #1;
      do_access(1, 0, 0, 32'h500, 32'h0, 1, mw(32'h500));
      do_access(1, 0, 0, 32'h50C, 32'h0, 0, mw(32'h50C));

      repeat (3) @(posedge clock);
      check_val("unexpected_beats", 32'(n_unexpected), 32'h0);
      check_val("beats_outstanding", 32'(exp_beats.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/data_cache.md
# data_cache

Parametrised direct-mapped, write-through, no-write-allocate data cache that sits between the MEM stage of the pipelined RISC-V core and a slower backing data memory. On a hit it returns data combinationally, exactly as the current flat data memory does. On a miss or store it raises `stall` to freeze the pipeline while a small state machine refills a line or performs the write-through over a request/acknowledge bus. It also carries the byte-store (`sb`) behaviour the core already relies on.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: byte-address width; data width is fixed at 32.
- `NUM_LINES`, 16: number of cache lines; power of two, at least 2.
- `WORDS_PER_LINE`, 4: 32-bit words per line; power of two, at least 1.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `dataAddress`  in  ADDR_WIDTH  byte address from EX_MEM.
- `writeData`  in  32  store data.
- `memRead`  in  1  load request.
- `memWrite`  in  1  store request.
- `sb`  in  1  store byte; when 0 a store writes the full word.
- `data`  out  32  load data, valid when `memRead`=1 and `stall`=0.
- `stall`  out  1  freeze the pipeline (PC, IF_ID, ID_EX, EX_MEM; bubble into MEM_WB).
- `mem_req`  out  1  backing-memory request.
- `mem_we`  out  1  1 = write beat, 0 = read beat.
- `mem_addr`  out  ADDR_WIDTH  word-aligned beat address (bits [1:0] = 0).
- `mem_wdata`  out  32  write data.
- `mem_be`  out  4  byte enables.
- `mem_rdata`  in  32  read data, valid while `mem_ack`=1.
- `mem_ack`  in  1  beat complete.

## Operation
- Address split, LSB first:
  - 2 byte-offset bits.
  - log2(WORDS_PER_LINE) word-offset bits.
  - log2(NUM_LINES) index bits.
  - Tag = the remaining bits.
- Per-line storage: valid bit, tag, and WORDS_PER_LINE data words.
- Hit: `valid[index]` is set and the stored tag equals the address tag.
- If `memRead` and `memWrite` are both 1, the access is treated as a store.
- FSM states:
  - IDLE: no access, or a read hit. `stall`=0 and `data` = the cached word.
    - Read miss: go to REFILL and assert `stall` in the same cycle, combinationally.
    - Any store: go to WRITE and assert `stall` in the same cycle.
    - A store hit updates the cached word at the IDLE edge. With `sb`=1 only byte lane `dataAddress[1:0]` takes `writeData[7:0]`; otherwise the full word is written.
    - A store miss leaves the array untouched (no-write-allocate).
  - REFILL: beat counter runs 0..WORDS_PER_LINE-1.
    - `mem_req`=1, `mem_we`=0, `mem_be`=4'hF, `mem_addr` = {tag, index, beat, 2'b00}.
    - On each `mem_ack`, `mem_rdata` is written to word[beat] and the counter increments.
    - On the last ack, set valid and tag, then return to IDLE. The access now hits and `stall` drops.
  - WRITE: `mem_req`=1 and `mem_we`=1.
    - `mem_addr` = the word-aligned `dataAddress`.
    - `sb`=1: `mem_wdata` = `writeData[7:0]` replicated into all four byte lanes, `mem_be` = one-hot of `dataAddress[1:0]`.
    - `sb`=0: `mem_wdata` = `writeData`, `mem_be`=4'hF.
    - On `mem_ack`, go to a one-cycle DONE state.
  - DONE: `stall`=0 and the FSM ignores the access so the pipeline can advance; return to IDLE next cycle.
- While `stall`=1 the core holds `dataAddress`, `writeData`, `memRead`, `memWrite` and `sb` stable. The cache does not re-register them.
- A conflicting line is simply overwritten; no write-back is needed.

## Timing
- Reset (`reset`=0, asynchronous):
  - All valid bits, the FSM (to IDLE) and the beat counter clear.
  - `stall`=0, `mem_req`=0, `mem_we`=0, `mem_be`=0, `mem_addr`=0, `mem_wdata`=0.
  - `data`=0 while no read is presented.
- Reset mid-refill or mid-write aborts the transaction. The partial line stays invalid, and `mem_req` drops asynchronously.
- Hit latency is 0 cycles (combinational). A store hit writes the array at the edge.
- Read-miss penalty = sum over beats of (ack latency + 1) + 1 cycles. Example: ack one cycle after each request with WORDS_PER_LINE=4 gives 9 stalled cycles.
- Store penalty = (ack latency + 1) + 1 cycles (WRITE plus DONE).
- `mem_req` stays high continuously across refill beats. `mem_addr` advances in the cycle after each ack.
- A beat is accepted only when `mem_req` and `mem_ack` are both 1 at the edge. `mem_ack` while `mem_req`=0 is ignored.

## Structure
- A shared package `cache_pkg` holds:
  - the state enum (IDLE, REFILL, WRITE, DONE);
  - field-width localparams derived via `$clog2` (OFFSET_W, INDEX_W, TAG_W);
  - the byte-lane enable function.
- Sub-module `cache_array`:
  - valid/tag/data storage with asynchronous clear of the valid bits;
  - one combinational read port;
  - one word write port with byte mask.
- The top level contains the FSM, beat counter and bus driving.

## Test plan
- Reset: drive `reset`=0 mid-run → all outputs 0 and FSM in IDLE; a subsequent load of 0x40 misses (`stall`=1).
- Read-miss refill: NUM_LINES=16, WORDS_PER_LINE=4, ack latency 1, load 0x104 → `mem_addr` sequence 0x100, 0x104, 0x108, 0x10C; `stall` high for 9 cycles; then `data` = memory[0x104].
- Read hit: after the refill, load 0x10C → `stall`=0 in the same cycle and `data` = memory[0x10C]; no `mem_req`.
- Byte-store hit: `sb`=1, address 0x106, `writeData`=0xAB → `mem_be`=4'b0100 and `mem_wdata`=0xABABABAB; a following load of 0x104 returns the old word with byte 2 = 0xAB.
- Store miss, no allocate: store 0xDEADBEEF to 0x200 → one write beat; a following load of 0x200 misses and refills.
- Conflict and abort: load 0x100, then load 0x500 (same index) → the line is replaced and 0x100 misses again. Assert reset during the second beat of a refill → `mem_req` falls immediately and the line stays invalid.
